// File: rtl/trace_buffer.sv
// Instruction trace buffer: captures fetch-stage PC, instruction and event flags into a circular store.
// Latency: an entry written on edge N is visible at the head from cycle N+1; the read head is combinational from storage.
// Backpressure: a pop needs rd_ready_in. When full, FIFO mode drops the new entry and ring mode overwrites the oldest.
//
// Ports:
//   Clk, Rst_n                      clock (rising edge) and async active-low reset
//   enable_in, mode_ring_in         capture enable; 1 = ring (overwrite oldest), 0 = FIFO (drop newest)
//   pc_in, instr_in                 fetch-stage PC and instruction word
//   stall_IF_ID_in, flush_*_in      hazard flags that disqualify the instruction
//   interrupt_in .. return_int_in   event flags; any set event forces a capture
//   rd_ready_in / rd_valid_out      consumer handshake for the head entry
//   rd_pc_out, rd_instr_out         head entry payload
//   rd_flags_out                    {instr_valid, return_interrupt, unstacking, stacking, interrupt}
//   count_out, full_out, empty_out  occupancy
//   dropped_out                     saturating lost-entry counter
//   rd_time_out                     head timestamp, present only with TRACE_TIMESTAMP_EN defined
//
// Optional feature macro: TRACE_TIMESTAMP_EN adds a free-running 32-bit cycle stamp to every entry.

module trace_buffer #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 16
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       enable_in,
  input  logic                       mode_ring_in,
  input  logic [PC_W-1:0]            pc_in,
  input  logic [INSTR_W-1:0]         instr_in,
  input  logic                       stall_IF_ID_in,
  input  logic                       flush_ID_in,
  input  logic                       flush_EX_in,
  input  logic                       interrupt_in,
  input  logic                       stacking_in,
  input  logic                       unstacking_in,
  input  logic                       return_interrupt_in,
  input  logic                       rd_ready_in,
  output logic                       rd_valid_out,
  output logic [PC_W-1:0]            rd_pc_out,
  output logic [INSTR_W-1:0]         rd_instr_out,
  output logic [4:0]                 rd_flags_out,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       full_out,
  output logic                       empty_out,
`ifdef TRACE_TIMESTAMP_EN
  output logic [31:0]                rd_time_out,
`endif
  output logic [15:0]                dropped_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  // Storage is deliberately left unreset; only the pointers define validity.
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [4:0]         flags_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   dropped_q, dropped_d;

  logic instr_valid;
  logic any_evt;
  logic wr_req;
  logic is_full;
  logic is_empty;
  logic pop;
  logic do_write;
  logic ovw;        // ring-mode overwrite of the oldest entry
  logic drop_inc;

  assign instr_valid = enable_in & ~stall_IF_ID_in & ~flush_ID_in & ~flush_EX_in;
  assign any_evt     = interrupt_in | stacking_in | unstacking_in | return_interrupt_in;
  assign wr_req      = enable_in & (instr_valid | any_evt);
  assign is_full     = (count_q == CNT_MAX);
  assign is_empty    = (count_q == '0);
  // Pop is qualified by registered occupancy only, so a same-cycle write is never bypassed.
  assign pop         = ~is_empty & rd_ready_in;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dropped_d = dropped_q;
    do_write  = 1'b0;
    ovw       = 1'b0;
    drop_inc  = 1'b0;

    if (wr_req) begin
      if (!is_full || pop) begin
        do_write = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else if (mode_ring_in) begin
        // Full ring: the write slot is the oldest slot, so both pointers move together.
        do_write = 1'b1;
        ovw      = 1'b1;
        drop_inc = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        drop_inc = 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    if ((do_write && !ovw) && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!(do_write && !ovw) && pop) begin
      count_d = count_q - CNT_ONE;
    end

    if (drop_inc && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_write) begin
      pc_mem[wr_ptr_q]    <= pc_in;
      instr_mem[wr_ptr_q] <= instr_in;
      flags_mem[wr_ptr_q] <= {instr_valid, return_interrupt_in, unstacking_in,
                              stacking_in, interrupt_in};
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] ts_mem [DEPTH];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_write) begin
      ts_mem[wr_ptr_q] <= ts_q;
    end
  end

  assign rd_time_out = ts_mem[rd_ptr_q];
`endif

  assign rd_valid_out = ~is_empty;
  assign rd_pc_out    = pc_mem[rd_ptr_q];
  assign rd_instr_out = instr_mem[rd_ptr_q];
  assign rd_flags_out = flags_mem[rd_ptr_q];
  assign count_out    = count_q;
  assign full_out     = is_full;
  assign empty_out    = is_empty;
  assign dropped_out  = dropped_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Self-checking bench for trace_buffer with a queue scoreboard of expected entries.
// Latency: inputs change 1 time unit after a rising edge; outputs sampled there too.
// Backpressure: rd_ready_in driven per cycle by the scenario tasks.

module tb_trace_buffer;

  localparam int DEPTH = 16;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        enable_in, mode_ring_in;
  logic [63:0] pc_in;
  logic [31:0] instr_in;
  logic        stall_IF_ID_in, flush_ID_in, flush_EX_in;
  logic        interrupt_in, stacking_in, unstacking_in, return_interrupt_in;
  logic        rd_ready_in;
  logic        rd_valid_out;
  logic [63:0] rd_pc_out;
  logic [31:0] rd_instr_out;
  logic [4:0]  rd_flags_out;
  logic [4:0]  count_out;
  logic        full_out, empty_out;
  logic [15:0] dropped_out;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] rd_time_out;
`endif

  trace_buffer #(.PC_W(64), .INSTR_W(32), .DEPTH(DEPTH)) dut (
    .Clk                 (Clk),
    .Rst_n               (Rst_n),
    .enable_in           (enable_in),
    .mode_ring_in        (mode_ring_in),
    .pc_in               (pc_in),
    .instr_in            (instr_in),
    .stall_IF_ID_in      (stall_IF_ID_in),
    .flush_ID_in         (flush_ID_in),
    .flush_EX_in         (flush_EX_in),
    .interrupt_in        (interrupt_in),
    .stacking_in         (stacking_in),
    .unstacking_in       (unstacking_in),
    .return_interrupt_in (return_interrupt_in),
    .rd_ready_in         (rd_ready_in),
    .rd_valid_out        (rd_valid_out),
    .rd_pc_out           (rd_pc_out),
    .rd_instr_out        (rd_instr_out),
    .rd_flags_out        (rd_flags_out),
    .count_out           (count_out),
    .full_out            (full_out),
    .empty_out           (empty_out),
`ifdef TRACE_TIMESTAMP_EN
    .rd_time_out         (rd_time_out),
`endif
    .dropped_out         (dropped_out)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  flags;
  } ent_t;

  ent_t exp_q[$];
  int   exp_drop;
  int   n_cmp;
  int   n_bad;

  function automatic logic [31:0] mk_instr(input logic [63:0] pc);
    logic [31:0] lo;
    lo = pc[31:0];
    return lo ^ 32'h1300_0013;
  endfunction

  // One clock of stimulus; the scoreboard is updated from the behaviour the
  // buffer must show at this edge. haz = {stall, flush_ID, flush_EX};
  // ev = {return_interrupt, unstacking, stacking, interrupt}.
  task automatic drive(input logic en, input logic ring, input logic [63:0] pc,
                       input logic [2:0] haz, input logic [3:0] ev, input logic rdy);
    ent_t e;
    ent_t tmp;
    logic iv, wr, full, pop;
    enable_in           = en;
    mode_ring_in        = ring;
    pc_in               = pc;
    instr_in            = mk_instr(pc);
    stall_IF_ID_in      = haz[2];
    flush_ID_in         = haz[1];
    flush_EX_in         = haz[0];
    return_interrupt_in = ev[3];
    unstacking_in       = ev[2];
    stacking_in         = ev[1];
    interrupt_in        = ev[0];
    rd_ready_in         = rdy;

    iv   = en & ~|haz;
    wr   = en & (iv | (|ev));
    full = (exp_q.size() == DEPTH);
    pop  = (exp_q.size() > 0) && rdy;
    e.pc = pc; e.instr = mk_instr(pc); e.flags = {iv, ev};
    if (pop) tmp = exp_q.pop_front();
    if (wr) begin
      if (full && !pop) begin
        if (exp_drop < 65535) exp_drop++;
        if (ring) begin
          tmp = exp_q.pop_front();
          exp_q.push_back(e);
        end
      end else begin
        exp_q.push_back(e);
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    #3;
    Rst_n = 1'b1;
    exp_q.delete();
    exp_drop = 0;
  endtask

  task automatic test_reset();
    n_cmp++; if (count_out !== 5'd0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", count_out); end
    n_cmp++; if (empty_out !== 1'b1) begin n_bad++; $display("FAIL reset_empty got=%b want=1", empty_out); end
    n_cmp++; if (full_out !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%b want=0", full_out); end
    n_cmp++; if (rd_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", rd_valid_out); end
    n_cmp++; if (dropped_out !== 16'd0) begin n_bad++; $display("FAIL reset_dropped got=%0d want=0", dropped_out); end
    Rst_n = 1'b1;
    exp_q.delete();
    exp_drop = 0;
  endtask

  // Pops everything the scoreboard holds, comparing each head before its pop.
  task automatic test_drain(input string tag);
    ent_t e;
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < DEPTH + 4) begin
      e = exp_q[0];
      n_cmp++;
      if (rd_valid_out !== 1'b1 || count_out !== 5'(exp_q.size())) begin
        n_bad++;
        $display("FAIL %s_occ valid=%b count=%0d want valid=1 count=%0d", tag, rd_valid_out, count_out, exp_q.size());
      end
      n_cmp++;
      if (rd_pc_out !== e.pc || rd_instr_out !== e.instr || rd_flags_out !== e.flags) begin
        n_bad++;
        $display("FAIL %s_head got pc=%h ins=%h fl=%b want pc=%h ins=%h fl=%b", tag,
                 rd_pc_out, rd_instr_out, rd_flags_out, e.pc, e.instr, e.flags);
      end
      drive(1'b0, 1'b0, 64'd0, 3'b000, 4'b0000, 1'b1);
      guard++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || empty_out !== 1'b1 || dropped_out !== 16'(exp_drop)) begin
      n_bad++;
      $display("FAIL %s_end empty=%b dropped=%0d want empty=1 dropped=%0d left=%0d", tag,
               empty_out, dropped_out, exp_drop, exp_q.size());
    end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 64'(i * 4), 3'b000, 4'b0000, 1'b0);
    n_cmp++; if (count_out !== 5'd3) begin n_bad++; $display("FAIL basic_count got=%0d want=3", count_out); end
    n_cmp++; if (rd_pc_out !== 64'h0) begin n_bad++; $display("FAIL basic_pc got=%h want=0", rd_pc_out); end
    n_cmp++; if (rd_flags_out !== 5'b10000) begin n_bad++; $display("FAIL basic_flags got=%b want=10000", rd_flags_out); end
    test_drain("basic");
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 64'h100 + 64'(i * 4), 3'b000, 4'b0000, 1'b0);
    n_cmp++; if (count_out !== 5'd16) begin n_bad++; $display("FAIL fifo_count got=%0d want=16", count_out); end
    n_cmp++; if (full_out !== 1'b1) begin n_bad++; $display("FAIL fifo_full got=%b want=1", full_out); end
    n_cmp++; if (dropped_out !== 16'd4) begin n_bad++; $display("FAIL fifo_dropped got=%0d want=4", dropped_out); end
    n_cmp++; if (rd_pc_out !== 64'h100) begin n_bad++; $display("FAIL fifo_head got=%h want=100", rd_pc_out); end
    test_drain("fifo");
  endtask

  task automatic test_ring();
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 64'h100 + 64'(i * 4), 3'b000, 4'b0000, 1'b0);
    n_cmp++; if (count_out !== 5'd16) begin n_bad++; $display("FAIL ring_count got=%0d want=16", count_out); end
    n_cmp++; if (dropped_out !== 16'd4) begin n_bad++; $display("FAIL ring_dropped got=%0d want=4", dropped_out); end
    n_cmp++; if (rd_pc_out !== 64'h110) begin n_bad++; $display("FAIL ring_head got=%h want=110", rd_pc_out); end
    // Full with simultaneous write and pop.
    drive(1'b1, 1'b1, 64'h900, 3'b000, 4'b0000, 1'b1);
    n_cmp++; if (count_out !== 5'd16) begin n_bad++; $display("FAIL wrpop_count got=%0d want=16", count_out); end
    n_cmp++; if (dropped_out !== 16'd4) begin n_bad++; $display("FAIL wrpop_dropped got=%0d want=4", dropped_out); end
    n_cmp++; if (rd_pc_out !== 64'h114) begin n_bad++; $display("FAIL wrpop_head got=%h want=114", rd_pc_out); end
    // Switch to FIFO while full: contents kept, the new write is dropped.
    drive(1'b1, 1'b0, 64'hA00, 3'b000, 4'b0000, 1'b0);
    n_cmp++; if (dropped_out !== 16'd5 || rd_pc_out !== 64'h114) begin
      n_bad++; $display("FAIL mode_switch dropped=%0d head=%h want dropped=5 head=114", dropped_out, rd_pc_out);
    end
    test_drain("ring");
  endtask

  task automatic test_flush_event();
    do_reset();
    drive(1'b1, 1'b0, 64'h40, 3'b001, 4'b0001, 1'b0);
    n_cmp++; if (count_out !== 5'd1 || rd_flags_out !== 5'b00001) begin
      n_bad++; $display("FAIL flush_evt count=%0d flags=%b want count=1 flags=00001", count_out, rd_flags_out);
    end
    drive(1'b1, 1'b0, 64'h44, 3'b001, 4'b0000, 1'b0);
    drive(1'b1, 1'b0, 64'h48, 3'b100, 4'b0000, 1'b0);
    n_cmp++; if (count_out !== 5'd1) begin n_bad++; $display("FAIL flush_noevt count=%0d want=1", count_out); end
    drive(1'b1, 1'b0, 64'h4C, 3'b010, 4'b0110, 1'b0);
    test_drain("flush");
  endtask

  task automatic test_enable_and_empty();
    do_reset();
    // Empty buffer: write with rd_ready high must not pop.
    drive(1'b1, 1'b0, 64'h200, 3'b000, 4'b0000, 1'b1);
    n_cmp++; if (count_out !== 5'd1 || rd_pc_out !== 64'h200) begin
      n_bad++; $display("FAIL empty_wr count=%0d pc=%h want count=1 pc=200", count_out, rd_pc_out);
    end
    drive(1'b1, 1'b0, 64'h204, 3'b000, 4'b1000, 1'b0);
    // Enable low: no capture even with events, but reads still pop.
    drive(1'b0, 1'b0, 64'h208, 3'b000, 4'b1111, 1'b1);
    n_cmp++; if (count_out !== 5'd1 || rd_pc_out !== 64'h204) begin
      n_bad++; $display("FAIL en_low count=%0d pc=%h want count=1 pc=204", count_out, rd_pc_out);
    end
    test_drain("enable");
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 64'h300 + 64'(i * 4), 3'b000, 4'b0000, 1'b0);
    #1;
    Rst_n = 1'b0;
    #1;
    n_cmp++; if (empty_out !== 1'b1 || count_out !== 5'd0 || rd_valid_out !== 1'b0) begin
      n_bad++; $display("FAIL async_rst empty=%b count=%0d valid=%b want 1/0/0", empty_out, count_out, rd_valid_out);
    end
    Rst_n = 1'b1;
    exp_q.delete();
    exp_drop = 0;
    drive(1'b1, 1'b0, 64'hABC, 3'b000, 4'b0000, 1'b0);
    n_cmp++; if (count_out !== 5'd1 || rd_pc_out !== 64'hABC) begin
      n_bad++; $display("FAIL post_rst count=%0d pc=%h want count=1 pc=abc", count_out, rd_pc_out);
    end
    // Fill past the wrap point so index ordering after reset is exercised.
    for (int i = 1; i < DEPTH; i++) drive(1'b1, 1'b0, 64'hB00 + 64'(i), 3'b000, 4'b0000, 1'b0);
    n_cmp++; if (full_out !== 1'b1) begin n_bad++; $display("FAIL post_rst_full got=%b want=1", full_out); end
    test_drain("async");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_drop = 0;
    Rst_n = 1'b0;
    enable_in = 1'b0; mode_ring_in = 1'b0; pc_in = '0; instr_in = '0;
    stall_IF_ID_in = 1'b0; flush_ID_in = 1'b0; flush_EX_in = 1'b0;
    interrupt_in = 1'b0; stacking_in = 1'b0; unstacking_in = 1'b0; return_interrupt_in = 1'b0;
    rd_ready_in = 1'b0;
    @(posedge Clk);
    #1;
    test_reset();
    test_basic();
    test_fifo_full();
    test_ring();
    test_flush_event();
    test_enable_and_empty();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter PC_W, default 64, fetch PC width.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction word width.
REQ-003 SHALL have parameter DEPTH, default 16, entry count (power of 2, >=4).
REQ-004 SHALL have the following ports; one clock; reset is asynchronous and active-low:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  async active-low reset.
- enable_in  in  1  capture enable.
- mode_ring_in  in  1  1 = ring (overwrite oldest); 0 = FIFO (drop newest when full).
- pc_in  in  PC_W  fetch-stage PC.
- instr_in  in  INSTR_W  fetch-stage instruction.
- stall_IF_ID_in, flush_ID_in, flush_EX_in  in  1 each  pipeline hazard flags.
- interrupt_in, stacking_in, unstacking_in, return_interrupt_in  in  1 each  event flags.
- rd_ready_in  in  1  consumer accepts head entry.
- rd_valid_out  out  1  head entry available.
- rd_pc_out  out  PC_W  head PC.
- rd_instr_out  out  INSTR_W  head instruction.
- rd_flags_out  out  5  {instr_valid, return_interrupt, unstacking, stacking, interrupt}.
- count_out  out  $clog2(DEPTH)+1  occupied entries.
- full_out, empty_out  out  1 each  occupancy flags.
- dropped_out  out  16  lost-entry counter, saturating.

Function
REQ-005 instr_valid SHALL be enable_in & ~stall_IF_ID_in & ~flush_ID_in & ~flush_EX_in.
REQ-006 Write SHALL occur when enable_in & (instr_valid | any event flag); the entry stores pc_in, instr_in and the 5 flag bits, sampled at the rising edge.
REQ-007 A written entry SHALL appear at the head no earlier than the cycle after its write edge (rd_valid_out registered-state based; no write-to-read bypass).
REQ-008 rd_valid_out SHALL equal ~empty_out; rd_*_out SHALL show the oldest entry combinationally from the storage array.
REQ-009 A pop SHALL occur on a rising edge with rd_valid_out & rd_ready_in; rd pointer advances by 1, modulo DEPTH.
REQ-010 Pointers SHALL wrap from DEPTH-1 to 0; count_out SHALL range 0..DEPTH.
REQ-011 Full, FIFO mode, write without pop: write SHALL be discarded; dropped_out increments by 1.
REQ-012 Full, ring mode, write without pop: entry SHALL overwrite the oldest; both pointers advance; count stays DEPTH; dropped_out increments by 1.
REQ-013 Full, write with pop (either mode): both SHALL complete; count stays DEPTH; dropped_out unchanged.
REQ-014 Empty, write with rd_ready_in high: no pop SHALL occur; count becomes 1.
REQ-015 dropped_out SHALL saturate at 16'hFFFF.
REQ-016 mode_ring_in SHALL take effect on the next edge with no flush of contents.
REQ-017 enable_in low SHALL block writes only; reads continue.

Reset
REQ-018 Rst_n low SHALL asynchronously clear pointers, count_out=0, empty_out=1, full_out=0, rd_valid_out=0, dropped_out=0; storage contents are not cleared.
REQ-019 Reset asserted mid-operation SHALL discard all entries; the first write after deassertion lands at index 0.

Configuration
REQ-020 Macro TRACE_TIMESTAMP_EN defined: a 32-bit free-running cycle counter (reset 0, wraps) is stored per entry and output on rd_time_out[31:0]; undefined: rd_time_out and the counter are absent.

Verification
REQ-021 Reset; 3 cycles valid instr at pc 0x0,0x4,0x8, rd_ready=0 -> count_out=3, head pc=0x0, flags=5'b10000.
REQ-022 FIFO mode, DEPTH=16, 20 valid writes, no pops -> count_out=16, full_out=1, dropped_out=4, head pc=first written.
REQ-023 Ring mode, same stimulus -> count_out=16, dropped_out=4, head pc = 5th written.
REQ-024 flush_EX_in=1 with interrupt_in=1 -> one entry, flags=5'b00001; flush with no event -> no entry.
REQ-025 Full, simultaneous write and pop -> count_out stays 16, dropped_out unchanged, new head = 2nd oldest.
REQ-026 Rst_n pulsed low between edges with 7 entries -> empty_out=1 immediately, next write stored at index 0.
